// File: rtl/instruction_fetch_if.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch_if
// Brief    : Instruction-memory request/response and decode-side handshake bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface instruction_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata,
        input  redirect,
        input  redirect_pc,
        output instr_valid,
        input  instr_ready,
        output instruction,
        output instr_pc
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata,
        output redirect,
        output redirect_pc,
        input  instr_valid,
        output instr_ready,
        input  instruction,
        input  instr_pc
    );
endinterface
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instruction_fetch
// Brief    : Sequential PC fetch over req/ack with a {pc, instr} FIFO toward decode.
//            Optional stall_count output enabled by INSTRUCTION_FETCH_STALL_COUNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    instruction_fetch_if.master    fetch_bus
`ifdef INSTRUCTION_FETCH_STALL_COUNT_EN
    ,
    output logic [31:0]            stall_count
`endif
);
    localparam int               PTR_W  = $clog2(FIFO_DEPTH);
    localparam int               CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] c_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_fetch_pc;
    logic [31:0]      w_fetch_pc_next;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_after_pop;
    logic [CNT_W-1:0] w_count_next;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr_next;
    logic [31:0]      r_mem_pc  [FIFO_DEPTH];
    logic [31:0]      r_mem_ins [FIFO_DEPTH];
    logic [31:0]      r_instruction;
    logic [31:0]      r_instr_pc;
    logic             w_valid;
    logic             w_pop;
    logic             w_ack_in_req;
    logic             w_push;
    logic             w_redirect;
    logic [31:0]      w_redirect_target;
    logic [1:0]       w_unused_pc_lsbs;

    assign w_redirect        = fetch_bus.redirect;
    assign w_redirect_target = {fetch_bus.redirect_pc[31:2], 2'b00};
    assign w_unused_pc_lsbs  = fetch_bus.redirect_pc[1:0];

    assign w_valid           = (r_count != '0);
    assign w_pop             = w_valid & fetch_bus.instr_ready;
    assign w_ack_in_req      = (r_state == S_REQ) & fetch_bus.imem_ack;
    assign w_push            = w_ack_in_req & ~w_redirect;
    assign w_count_after_pop = r_count - CNT_W'(w_pop);
    assign w_count_next      = w_redirect ? '0 : (w_count_after_pop + CNT_W'(w_push));
    assign w_rd_ptr_next     = r_rd_ptr + PTR_W'(w_pop);

    // A redirect always wins; an ack that coincides with it closes the old request.
    always_comb begin
        w_state_next    = r_state;
        w_fetch_pc_next = r_fetch_pc;
        case (r_state)
            S_IDLE: begin
                if (r_count < c_FULL) begin
                    w_state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (fetch_bus.imem_ack) begin
                    w_fetch_pc_next = r_fetch_pc + 32'd4;
                    w_state_next    = (w_count_next < c_FULL) ? S_REQ : S_IDLE;
                end
            end
            S_DROP: begin
                if (fetch_bus.imem_ack) begin
                    w_state_next = S_REQ;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_redirect) begin
            w_fetch_pc_next = w_redirect_target;
            w_state_next    = ((r_state != S_IDLE) && !fetch_bus.imem_ack) ? S_DROP : S_REQ;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
        end else begin
            r_state    <= w_state_next;
            r_fetch_pc <= w_fetch_pc_next;
        end
    end

    // Head is registered so it holds its last value once the FIFO drains.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_instruction <= 32'h0;
            r_instr_pc    <= 32'h0;
        end else if (w_redirect) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_count  <= w_count_next;
            r_rd_ptr <= w_rd_ptr_next;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_push && (w_count_after_pop == '0)) begin
                r_instruction <= fetch_bus.imem_rdata;
                r_instr_pc    <= r_fetch_pc;
            end else if (w_count_after_pop != '0) begin
                r_instruction <= r_mem_ins[w_rd_ptr_next];
                r_instr_pc    <= r_mem_pc[w_rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem_pc[r_wr_ptr]  <= r_fetch_pc;
            r_mem_ins[r_wr_ptr] <= fetch_bus.imem_rdata;
        end
    end

    assign fetch_bus.imem_req    = (r_state == S_REQ);
    assign fetch_bus.imem_addr   = r_fetch_pc;
    assign fetch_bus.instr_valid = w_valid;
    assign fetch_bus.instruction = r_instruction;
    assign fetch_bus.instr_pc    = r_instr_pc;

`ifdef INSTRUCTION_FETCH_STALL_COUNT_EN
    logic [31:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_count <= 32'h0;
        end else if (!w_valid && (r_stall_count != 32'hFFFF_FFFF)) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire
